// File: rtl/usart_receiver.sv
// -----------------------------------------------------------------------------
// usart_receiver
//
// Receive half of the USART. Turns the serial RxD line into characters and
// parks each completed character in a one-entry buffer, together with the
// frame and parity status that the register file exposes.
//
// Asynchronous mode oversamples RxD on every i_rxclk tick (16 ticks per bit,
// or 8 with U2X) and takes a 2-of-3 majority around the middle of each bit.
// Synchronous mode samples RxD once per i_rxclk pulse.
//
// Ports
//   i_fosk     system clock
//   i_rst_n    asynchronous active-low reset
//   i_rxclk    receive enable pulse (oversample tick / sync sample edge)
//   i_rxd      serial data line, asynchronous to i_fosk
//   i_rxen     receiver enable; low aborts any frame and clears status
//   i_umsel    1 = synchronous, 0 = asynchronous
//   i_u2x      double speed (8 ticks per bit), async only
//   i_ucsz     character size: 000=5 001=6 010=7 011=8 111=9, others 8
//   i_upm      parity: 0x none, 10 even, 11 odd
//   i_re_udr   one-cycle UDR read strobe
//   o_data     received character, LSB aligned, unused MSBs zero
//   o_rxc      buffer holds an unread character
//   o_fe       frame error of the buffered character
//   o_upe      parity error of the buffered character
//   o_dor      data overrun (sticky until read or disable)
// -----------------------------------------------------------------------------
module usart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_fosk,
  input  logic       i_rst_n,
  input  logic       i_rxclk,
  input  logic       i_rxd,
  input  logic       i_rxen,
  input  logic       i_umsel,
  input  logic       i_u2x,
  input  logic [2:0] i_ucsz,
  input  logic [1:0] i_upm,
  input  logic       i_re_udr,
  output logic [8:0] o_data,
  output logic       o_rxc,
  output logic       o_fe,
  output logic       o_upe,
  output logic       o_dor
);

  // Fewer than two flops would not give the line a chance to settle.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state_q, state_d;

  logic [SS-1:0] sync_q;
  logic          rxd_s;

  // Frame configuration, captured when a start bit is detected.
  logic          cfg_sync;
  logic          cfg_u2x;
  logic [3:0]    cfg_nbits;
  logic          cfg_par;
  logic          cfg_odd;

  logic [3:0]    tick_cnt;
  logic [3:0]    bit_cnt;
  logic          samp_a, samp_b;
  logic [8:0]    shift_q;
  logic          upe_pend;

  // Completed frame waiting one cycle for the buffer logic.
  logic          deliver_q;
  logic [8:0]    frm_data;
  logic          frm_fe;
  logic          frm_upe;

  logic [3:0]    last_tick, vote_tick;
  logic          maj, bit_val, samp_ev, end_ev, last_bit;

  // FSM strobes towards the datapath.
  logic          start_det, do_shift, bit_adv, bit_clr, chk_par, do_stop;

  function automatic logic [3:0] char_bits(input logic [2:0] ucsz);
    case (ucsz)
      3'b000:  return 4'd5;
      3'b001:  return 4'd6;
      3'b010:  return 4'd7;
      3'b111:  return 4'd9;
      default: return 4'd8;
    endcase
  endfunction

  assign rxd_s     = sync_q[SS-1];
  assign last_tick = cfg_u2x ? 4'd7 : 4'd15;
  assign vote_tick = cfg_u2x ? 4'd5 : 4'd9;
  assign maj       = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);
  // In sync mode every pulse is both the sample point and the end of a bit.
  assign bit_val   = cfg_sync ? rxd_s : maj;
  assign samp_ev   = cfg_sync ? i_rxclk : (i_rxclk && (tick_cnt == vote_tick));
  assign end_ev    = cfg_sync ? i_rxclk : (i_rxclk && (tick_cnt == last_tick));
  assign last_bit  = (bit_cnt == (cfg_nbits - 4'd1));

  // RxD synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '1;
    else          sync_q <= {sync_q[SS-2:0], i_rxd};
  end

  // State register.
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and datapath strobes. The sync-mode start state consumes the
  // first data bit directly, because the start bit was already sampled in IDLE.
  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    do_shift  = 1'b0;
    bit_adv   = 1'b0;
    bit_clr   = 1'b0;
    chk_par   = 1'b0;
    do_stop   = 1'b0;
    if (!i_rxen) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_rxclk && !rxd_s) begin
            state_d   = START;
            start_det = 1'b1;
          end
        end
        START: begin
          if (cfg_sync) begin
            if (i_rxclk) begin
              do_shift = 1'b1;
              bit_adv  = 1'b1;
              state_d  = DATA;
            end
          end else if (samp_ev && bit_val) begin
            state_d = IDLE;
          end else if (end_ev) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (samp_ev) do_shift = 1'b1;
          if (end_ev) begin
            if (last_bit) begin
              bit_clr = 1'b1;
              state_d = cfg_par ? PARITY : STOP;
            end else begin
              bit_adv = 1'b1;
            end
          end
        end
        PARITY: begin
          if (samp_ev) chk_par = 1'b1;
          if (end_ev)  state_d = STOP;
        end
        STOP: begin
          if (samp_ev) begin
            do_stop = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Oversample tick counter; the detecting tick counts as tick 0 of the start bit.
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n)                 tick_cnt <= 4'd0;
    else if (state_d == IDLE)     tick_cnt <= 4'd0;
    else if (start_det)           tick_cnt <= 4'd1;
    else if (!cfg_sync && i_rxclk)
      tick_cnt <= (tick_cnt == last_tick) ? 4'd0 : tick_cnt + 4'd1;
  end

  // First two of the three majority samples; the third is taken live.
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (!cfg_sync && i_rxclk) begin
      if (tick_cnt == (vote_tick - 4'd2)) samp_a <= rxd_s;
      if (tick_cnt == (vote_tick - 4'd1)) samp_b <= rxd_s;
    end
  end

  // Frame configuration latch.
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_sync  <= 1'b0;
      cfg_u2x   <= 1'b0;
      cfg_nbits <= 4'd8;
      cfg_par   <= 1'b0;
      cfg_odd   <= 1'b0;
    end else if (start_det) begin
      cfg_sync  <= i_umsel;
      cfg_u2x   <= i_u2x;
      cfg_nbits <= char_bits(i_ucsz);
      cfg_par   <= i_upm[1];
      cfg_odd   <= i_upm[0];
    end
  end

  // Shift register fills from the top, LSB first, so the character ends up in
  // the upper cfg_nbits bits and is right-aligned on delivery. Clearing it at
  // each start keeps the unused bits zero for the parity reduction.
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q  <= 9'd0;
      bit_cnt  <= 4'd0;
      upe_pend <= 1'b0;
    end else if (!i_rxen || start_det) begin
      shift_q  <= 9'd0;
      bit_cnt  <= 4'd0;
      upe_pend <= 1'b0;
    end else begin
      if (do_shift) shift_q <= {bit_val, shift_q[8:1]};
      if (bit_clr)       bit_cnt <= 4'd0;
      else if (bit_adv)  bit_cnt <= bit_cnt + 4'd1;
      if (chk_par) upe_pend <= bit_val ^ (^shift_q) ^ cfg_odd;
    end
  end

  // Capture the finished frame at the stop sample for delivery next cycle.
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deliver_q <= 1'b0;
      frm_data  <= 9'd0;
      frm_fe    <= 1'b0;
      frm_upe   <= 1'b0;
    end else begin
      deliver_q <= do_stop && i_rxen;
      if (do_stop) begin
        frm_data <= shift_q >> (4'd9 - cfg_nbits);
        frm_fe   <= ~bit_val;
        frm_upe  <= upe_pend;
      end
    end
  end

  // One-entry receive buffer. A read in the delivery cycle frees the slot in
  // time for the new character, so that case is not an overrun.
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= 9'd0;
      o_rxc  <= 1'b0;
      o_fe   <= 1'b0;
      o_upe  <= 1'b0;
      o_dor  <= 1'b0;
    end else if (!i_rxen) begin
      o_rxc  <= 1'b0;
      o_fe   <= 1'b0;
      o_upe  <= 1'b0;
      o_dor  <= 1'b0;
    end else if (deliver_q) begin
      if (!o_rxc || i_re_udr) begin
        o_data <= frm_data;
        o_fe   <= frm_fe;
        o_upe  <= frm_upe;
        o_rxc  <= 1'b1;
        if (i_re_udr) o_dor <= 1'b0;
      end else begin
        o_dor  <= 1'b1;
      end
    end else if (i_re_udr && o_rxc) begin
      o_rxc  <= 1'b0;
      o_dor  <= 1'b0;
    end
  end

endmodule
